// File: rtl/fir_pkg.sv
// Shared types and constants for the folded symmetric FIR front end.
// The window, coefficient file and datapath sequencing all use these types.
package fir_pkg;

    localparam int SAMP_W     = 24;
    localparam int COEF_W     = 27;
    localparam int NUM_TAPS   = 29;
    localparam int NUM_COEF   = 15;
    localparam int NUM_BLOCKS = 5;
    localparam int NUM_PHASES = 3;

    typedef struct packed {
        logic signed [SAMP_W-1:0] I;
        logic signed [SAMP_W-1:0] Q;
    } Samp;

    typedef struct packed {
        logic signed [COEF_W-1:0] I;
        logic signed [COEF_W-1:0] Q;
    } Coef;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH0  = 2'd1,
        PH1  = 2'd2,
        PH2  = 2'd3
    } phase_t;

endpackage

// File: rtl/fir_ctrl_pipe.sv
// Tagged delay line that follows each issued MAC phase through the multiplier
// latency and turns it into the accumulate-select and final-sum strobes.
import fir_pkg::*;

module fir_ctrl_pipe #(
    parameter int MULT_LAT = 2
) (
    input  logic   clk,
    input  logic   reset,
    input  phase_t issue,
    output logic   partialProductAccumulate_valid,
    output logic   finalAccumulateRounding_en
);

    localparam int DEPTH = MULT_LAT + 4;

    phase_t tag [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag[i] <= IDLE;
            end
        end else begin
            tag[0] <= issue;
            for (int i = 1; i < DEPTH; i++) begin
                tag[i] <= tag[i-1];
            end
        end
    end

    // PH0 products load the accumulator; PH1/PH2 products add onto it.
    assign partialProductAccumulate_valid = (tag[MULT_LAT] == PH1) || (tag[MULT_LAT] == PH2);

    // The load tag reaching the end means all three partials are summed.
    assign finalAccumulateRounding_en = (tag[DEPTH-1] == PH0);

endmodule

// File: rtl/fir_sample_window.sv
// Sample window, coefficient file and 3-phase fold sequencer feeding fir_datapath.
//   state | meaning
//   IDLE  | no sample in flight, ready to accept
//   PH0   | first fold phase issued, window held, StopIn high
//   PH1   | second fold phase issued, window held, StopIn high
//   PH2   | last fold phase issued, next sample may be accepted
import fir_pkg::*;

module fir_sample_window #(
    parameter int TAPS     = 29,
    parameter int MULT_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 PushIn,
    input  Samp                  SampIn,
    output logic                 StopIn,
    input  logic                 CoefWr,
    input  logic [3:0]           CoefAddr,
    input  Coef                  CoefIn,
    output Samp  [TAPS-1:0]      samp,
    output Coef  [NUM_COEF-1:0]  coef,
    output logic [1:0]           mux_sel,
    output logic                 partialProductAccumulate_valid,
    output logic                 finalAccumulateRounding_en
);

    if (TAPS != NUM_TAPS) begin : g_taps_check
        $error("fir_sample_window: TAPS must be 29 for the 5x3 fold");
    end

    phase_t state;
    logic   accept;

    assign StopIn = (state == PH0) || (state == PH1);
    assign accept = PushIn && !StopIn;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            mux_sel <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) state <= PH0;
                    mux_sel <= 2'd0;
                end
                PH0: begin
                    state   <= PH1;
                    mux_sel <= 2'd1;
                end
                PH1: begin
                    state   <= PH2;
                    mux_sel <= 2'd2;
                end
                PH2: begin
                    state   <= accept ? PH0 : IDLE;
                    mux_sel <= 2'd0;
                end
                default: begin
                    state   <= IDLE;
                    mux_sel <= 2'd0;
                end
            endcase
        end
    end

    // Shifting at the PH2 edge is safe: the datapath captures the old window on that same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp <= '0;
        end else if (accept) begin
            samp <= {samp[TAPS-2:0], SampIn};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coef <= '0;
        end else if (CoefWr && (CoefAddr < 4'(NUM_COEF))) begin
            coef[CoefAddr] <= CoefIn;
        end
    end

    fir_ctrl_pipe #(
        .MULT_LAT (MULT_LAT)
    ) u_ctrl_pipe (
        .clk                            (clk),
        .reset                          (reset),
        .issue                          (state),
        .partialProductAccumulate_valid (partialProductAccumulate_valid),
        .finalAccumulateRounding_en     (finalAccumulateRounding_en)
    );

endmodule

// File: tb/tb_fir_sample_window.sv
// Scoreboard bench for fir_sample_window: a cycle-indexed reference of the fold
// schedule plus window/final-strobe queues popped by an independent monitor.
module tb_fir_sample_window;
    import fir_pkg::*;

    localparam int ML   = 2;
    localparam int MAXC = 2048;
    typedef Samp [NUM_TAPS-1:0] win_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                PushIn = 1'b0;
    Samp                 SampIn = '0;
    logic                StopIn;
    logic                CoefWr = 1'b0;
    logic [3:0]          CoefAddr = 4'd0;
    Coef                 CoefIn = '0;
    win_t                samp;
    Coef [NUM_COEF-1:0]  coef;
    logic [1:0]          mux_sel;
    logic                pav;
    logic                fre;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   run = 1'b0;

    bit         exp_stop [MAXC];
    logic [1:0] exp_mux  [MAXC];
    bit         exp_pav  [MAXC];
    bit         exp_fre  [MAXC];
    win_t       win_q [$];
    int         fre_q [$];
    Samp        hist [$];
    Coef        coef_m [NUM_COEF];
    int         fre_count = 0;
    int         last_fre = -100;

    fir_sample_window #(.TAPS(29), .MULT_LAT(ML)) dut (
        .clk                            (clk),
        .reset                          (reset),
        .PushIn                         (PushIn),
        .SampIn                         (SampIn),
        .StopIn                         (StopIn),
        .CoefWr                         (CoefWr),
        .CoefAddr                       (CoefAddr),
        .CoefIn                         (CoefIn),
        .samp                           (samp),
        .coef                           (coef),
        .mux_sel                        (mux_sel),
        .partialProductAccumulate_valid (pav),
        .finalAccumulateRounding_en     (fre)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic model_clear();
        hist.delete();
        for (int i = 0; i < NUM_TAPS; i++) hist.push_back('0);
        for (int i = 0; i < NUM_COEF; i++) coef_m[i] = '0;
        for (int i = cyc; i < MAXC; i++) begin
            exp_stop[i] = 1'b0;
            exp_mux[i]  = 2'd0;
            exp_pav[i]  = 1'b0;
            exp_fre[i]  = 1'b0;
        end
        win_q.delete();
        fre_q.delete();
        last_fre = -100;
    endtask

    // One accepted sample: PH0..PH2 on the next three cycles, load/acc/acc
    // after the multiplier latency, one final-sum pulse after that.
    task automatic issue(input Samp s);
        int   a;
        win_t w;
        a = cyc;
        hist.push_front(s);
        void'(hist.pop_back());
        for (int i = 0; i < NUM_TAPS; i++) w[i] = hist[i];
        win_q.push_back(w);
        exp_stop[a+1] = 1'b1;
        exp_stop[a+2] = 1'b1;
        exp_mux[a+1]  = 2'd0;
        exp_mux[a+2]  = 2'd1;
        exp_mux[a+3]  = 2'd2;
        exp_pav[a+ML+3] = 1'b1;
        exp_pav[a+ML+4] = 1'b1;
        exp_fre[a+ML+5] = 1'b1;
        fre_q.push_back(a + ML + 5);
    endtask

    // Called 2 time units after a rising edge; consumes exactly one cycle.
    task automatic step(input logic push, input Samp s, input logic cwr,
                        input logic [3:0] ca, input Coef cd, output bit acc);
        int k;
        k = cyc % NUM_COEF;
        for (int i = 0; i < NUM_COEF; i++) if (coef[i] !== coef_m[i]) k = i;
        chk($sformatf("coef[%0d]", k), {10'b0, coef[k]}, {10'b0, coef_m[k]});
        PushIn   = push;
        SampIn   = s;
        CoefWr   = cwr;
        CoefAddr = ca;
        CoefIn   = cd;
        acc = push && !exp_stop[cyc];
        if (acc) issue(s);
        if (cwr && ca < 4'd15) coef_m[ca] = cd;
        @(posedge clk);
        #2;
    endtask

    task automatic push_wait(input Samp s);
        bit acc;
        acc = 1'b0;
        for (int t = 0; t < 4 && !acc; t++) step(1'b1, s, 1'b0, 4'd0, '0, acc);
        if (!acc) chk("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 4'd0, '0, acc);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        PushIn = 1'b0;
        CoefWr = 1'b0;
        model_clear();
        #1;
        chk("rst_samp_nonzero", {63'b0, |samp}, 64'd0);
        chk("rst_coef_nonzero", {63'b0, |coef}, 64'd0);
        chk("rst_mux_sel", {62'b0, mux_sel}, 64'd0);
        chk("rst_stop", {63'b0, StopIn}, 64'd0);
        chk("rst_pav", {63'b0, pav}, 64'd0);
        chk("rst_fre", {63'b0, fre}, 64'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        win_t w;
        int   k;
        if (run && !reset) begin
            chk("stop", {63'b0, StopIn}, {63'b0, exp_stop[cyc]});
            chk("mux_sel", {62'b0, mux_sel}, {62'b0, exp_mux[cyc]});
            chk("pav", {63'b0, pav}, {63'b0, exp_pav[cyc]});
            chk("fre", {63'b0, fre}, {63'b0, exp_fre[cyc]});
            if (StopIn && mux_sel == 2'd0) begin
                if (win_q.size() == 0) begin
                    chk("window_unexpected", 64'd1, 64'd0);
                end else begin
                    w = win_q.pop_front();
                    k = cyc % NUM_TAPS;
                    for (int i = 0; i < NUM_TAPS; i++) if (samp[i] !== w[i]) k = i;
                    chk($sformatf("window[%0d]", k), {16'b0, samp[k]}, {16'b0, w[k]});
                end
            end
            if (fre) begin
                fre_count++;
                if (fre_q.size() == 0) chk("fre_unexpected", 64'd1, 64'd0);
                else chk("fre_cycle", 64'(cyc), 64'(fre_q.pop_front()));
                if (last_fre >= 0) chk("fre_gap_ge3", {63'b0, (cyc - last_fre) >= 3}, 64'd1);
                last_fre = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit  acc;
        Samp s;
        Coef c;
        int  n0;

        model_clear();
        @(posedge clk);
        #2;
        do_reset();
        run = 1'b1;

        // Single tap coefficient, one sample into IDLE.
        c = '0;
        c.I = 27'h0400000;
        step(1'b0, '0, 1'b1, 4'd0, c, acc);
        n0 = fre_count;
        s = '0;
        s.I = 24'h200000;
        step(1'b1, s, 1'b0, 4'd0, '0, acc);
        idle(10);
        chk("single_fre_count", 64'(fre_count - n0), 64'd1);

        // PushIn held high across 30 incrementing samples.
        n0 = fre_count;
        for (int i = 1; i <= 30; i++) begin
            s.I = 24'(i);
            s.Q = 24'($urandom);
            push_wait(s);
        end
        chk("burst_newest", {40'b0, samp[0].I}, 64'd30);
        chk("burst_oldest", {40'b0, samp[28].I}, 64'd2);
        idle(10);
        chk("burst_fre_count", 64'(fre_count - n0), 64'd30);

        // Reset in PH1 after three pushes drops the in-flight results.
        for (int i = 0; i < 3; i++) begin
            s.I = 24'($urandom);
            s.Q = 24'($urandom);
            push_wait(s);
        end
        idle(1);
        do_reset();
        n0 = fre_count;
        idle(10);
        chk("post_reset_fre", 64'(fre_count - n0), 64'd0);

        // Address 15 is ignored; address 14 takes -1.
        c = '0;
        c.I = 27'h1;
        step(1'b0, '0, 1'b1, 4'd15, c, acc);
        chk("coef_addr15_ignored", {63'b0, |coef}, 64'd0);
        c.I = 27'h7FFFFFF;
        step(1'b0, '0, 1'b1, 4'd14, c, acc);
        chk("coef14_I", {37'b0, coef[14].I}, {37'b0, 27'h7FFFFFF});

        // Single push then quiet.
        s.I = 24'($urandom);
        s.Q = 24'($urandom);
        push_wait(s);
        idle(20);
        chk("quiet_mux_sel", {62'b0, mux_sel}, 64'd0);
        chk("quiet_stop", {63'b0, StopIn}, 64'd0);

        // Random traffic with coefficient writes and one mid-stream reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            s.I = 24'($urandom);
            s.Q = 24'($urandom);
            c.I = 27'($urandom);
            c.Q = 27'($urandom);
            step($urandom_range(0, 9) < 6, s, $urandom_range(0, 9) == 0,
                 4'($urandom_range(0, 15)), c, acc);
        end
        idle(15);
        chk("win_q_drained", 64'(win_q.size()), 64'd0);
        chk("fre_q_drained", 64'(fre_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
